// File: rtl/lpm_add_sub_seq_pkg.sv
// Shared definitions for the LPM word-serial sequencers: FSM encoding,
// carry-in defaults and index sizing.
package lpm_add_sub_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  // Value a floating cin resolves to, per operation.
  localparam logic CIN_DEFAULT_ADD = 1'b0;
  localparam logic CIN_DEFAULT_SUB = 1'b1;

  // A single-word sequencer still needs a one-bit index register.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/lpm_add_sub.sv
// Zero-latency add/subtract slice. For subtraction cin is the active-high
// "no borrow" input and cout is the active-high "no borrow" output.
module lpm_add_sub #(
  parameter int lpm_width          = 8,
  parameter     lpm_representation = "UNSIGNED",
  parameter     lpm_direction      = "UNUSED"
) (
  input  logic [lpm_width-1:0] dataa,
  input  logic [lpm_width-1:0] datab,
  input  logic                 cin,
  input  logic                 add_sub,
  input  logic                 aclr,
  output logic [lpm_width-1:0] result,
  output logic                 cout,
  output logic                 overflow
);

  localparam bit IS_SIGNED = (lpm_representation == "SIGNED");
  localparam bit FORCE_ADD = (lpm_direction == "ADD");
  localparam bit FORCE_SUB = (lpm_direction == "SUB");
  localparam int MSB       = lpm_width - 1;

  logic                 w_add;
  logic [lpm_width-1:0] w_b_eff;
  logic [lpm_width-1:0] w_sum;
  logic                 w_carry;
  logic                 w_ovf;

  assign w_add = FORCE_ADD ? 1'b1 : (FORCE_SUB ? 1'b0 : add_sub);

  // Subtraction is a + ~b + cin, so cin=1 gives a plain a-b.
  assign w_b_eff = w_add ? datab : ~datab;
  assign {w_carry, w_sum} = {1'b0, dataa} + {1'b0, w_b_eff} + {{lpm_width{1'b0}}, cin};

  assign w_ovf = IS_SIGNED
               ? ((dataa[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != dataa[MSB]))
               : (w_add ? w_carry : ~w_carry);

  assign result   = aclr ? '0   : w_sum;
  assign cout     = aclr ? 1'b0 : w_carry;
  assign overflow = aclr ? 1'b0 : w_ovf;

endmodule

// File: rtl/lpm_add_sub_seq.sv
// Word-serial wide add/subtract: one lpm_add_sub slice processes the operands
// LS word first, one word per enabled clock, chaining the carry between words.
module lpm_add_sub_seq
  import lpm_add_sub_seq_pkg::*;
#(
  parameter int lpm_width          = 8,
  parameter int lpm_words          = 4,
  parameter     lpm_representation = "UNSIGNED"
) (
  input  logic                           clock,
  input  logic                           sclr,
  input  logic                           clken,
  input  logic                           start,
  input  logic                           add_sub,
  input  logic                           cin,
  input  logic [lpm_width*lpm_words-1:0] dataa,
  input  logic [lpm_width*lpm_words-1:0] datab,
  output logic                           busy,
  output logic                           done,
  output logic [lpm_width*lpm_words-1:0] result,
  output logic                           cout,
  output logic                           overflow
);

  localparam int              W         = lpm_width * lpm_words;
  localparam int              IDX_W     = idx_width(lpm_words);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(lpm_words - 1);
  localparam bit              IS_SIGNED = (lpm_representation == "SIGNED");

  seq_state_t       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_add;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_accum;
  logic [W-1:0]     r_result;
  logic             r_cout;
  logic             r_overflow;
  logic             r_done;

  logic [lpm_width-1:0] w_a_sel;
  logic [lpm_width-1:0] w_b_sel;
  logic [lpm_width-1:0] w_sum;
  logic                 w_slice_cout;
  logic                 w_slice_ovf;
  logic [W-1:0]         w_accum_next;
  logic                 w_signed_ovf;

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < lpm_words; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_sel = r_a[i*lpm_width +: lpm_width];
        w_b_sel = r_b[i*lpm_width +: lpm_width];
      end
    end
  end

  lpm_add_sub #(
    .lpm_width          (lpm_width),
    .lpm_representation ("UNSIGNED"),
    .lpm_direction      ("UNUSED")
  ) u_slice (
    .dataa    (w_a_sel),
    .datab    (w_b_sel),
    .cin      (r_carry),
    .add_sub  (r_add),
    .aclr     (1'b0),
    .result   (w_sum),
    .cout     (w_slice_cout),
    .overflow (w_slice_ovf)
  );

  // Accumulator with the current slice patched in; on the last slice this is the final result.
  for (genvar gi = 0; gi < lpm_words; gi++) begin : g_word
    assign w_accum_next[gi*lpm_width +: lpm_width] =
      (r_idx == IDX_W'(gi)) ? w_sum : r_accum[gi*lpm_width +: lpm_width];
  end

  assign w_signed_ovf = r_add
    ? ((r_a[W-1] == r_b[W-1]) && (w_accum_next[W-1] != r_a[W-1]))
    : ((r_a[W-1] != r_b[W-1]) && (w_accum_next[W-1] != r_a[W-1]));

  always_ff @(posedge clock) begin
    if (sclr) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_add      <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_accum    <= '0;
      r_result   <= '0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else if (clken) begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= dataa;
            r_b     <= datab;
            r_add   <= add_sub;
            r_carry <= cin;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_accum <= w_accum_next;
          r_carry <= w_slice_cout;
          if (r_idx == LAST_IDX) begin
            r_result   <= w_accum_next;
            r_cout     <= w_slice_cout;
            // The unsigned slice already reports the unsigned rule on its carry.
            r_overflow <= IS_SIGNED ? w_signed_ovf : w_slice_ovf;
            r_done     <= 1'b1;
            r_idx      <= '0;
            r_state    <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
  assign result   = r_result;
  assign cout     = r_cout;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_lpm_add_sub_seq.sv
// Bench for lpm_add_sub_seq: an UNSIGNED and a SIGNED instance share stimulus;
// directed table, random ops against an integer model, and stall/abort/back-to-back sequences.
module tb_lpm_add_sub_seq;
  import lpm_add_sub_seq_pkg::*;

  localparam int LW = 8;
  localparam int NW = 4;
  localparam int W  = LW * NW;

  logic         clock = 1'b0;
  logic         sclr, clken, start, add_sub, cin;
  logic [W-1:0] dataa, datab;
  logic         busy_u, done_u, cout_u, ovf_u;
  logic         busy_s, done_s, cout_s, ovf_s;
  logic [W-1:0] result_u, result_s;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] last_r = '0;

  always #5 clock = ~clock;

  lpm_add_sub_seq #(.lpm_width(LW), .lpm_words(NW), .lpm_representation("UNSIGNED")) u_dut_u (
    .clock(clock), .sclr(sclr), .clken(clken), .start(start), .add_sub(add_sub), .cin(cin),
    .dataa(dataa), .datab(datab), .busy(busy_u), .done(done_u), .result(result_u),
    .cout(cout_u), .overflow(ovf_u)
  );

  lpm_add_sub_seq #(.lpm_width(LW), .lpm_words(NW), .lpm_representation("SIGNED")) u_dut_s (
    .clock(clock), .sclr(sclr), .clken(clken), .start(start), .add_sub(add_sub), .cin(cin),
    .dataa(dataa), .datab(datab), .busy(busy_s), .done(done_s), .result(result_s),
    .cout(cout_s), .overflow(ovf_s)
  );

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         add;
    logic         c;
    logic [W-1:0] r;
    logic         co;
    logic         ovu;
    logic         ovs;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Integer reference: true sum/difference, carry = no wrap/no borrow, overflow = out of range.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic add, input logic c,
                       output logic [W-1:0] r, output logic co, output logic ovu, output logic ovs);
    longint ua, ub, sa, sb, usum, ssum, ci;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = $signed(a);
    sb = $signed(b);
    ci = c ? 64'sd1 : 64'sd0;
    if (add) begin
      usum = ua + ub + ci;
      ssum = sa + sb + ci;
      co   = (usum >= 64'sd4294967296);
    end else begin
      usum = ua - ub - (64'sd1 - ci);
      ssum = sa - sb - (64'sd1 - ci);
      co   = (usum >= 64'sd0);
    end
    r   = usum[W-1:0];
    ovu = add ? co : !co;
    ovs = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic add, input logic c);
    @(negedge clock);
    dataa = a; datab = b; add_sub = add; cin = c; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done_u && lat < 20) begin
      if (busy_u) busy_cnt++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic add, input logic c, input logic [W-1:0] r,
                           input logic co, input logic ovu, input logic ovs);
    int lat, bc;
    issue(a, b, add, c);
    wait_done(lat, bc);
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " busy_cycles"}, 64'(bc), 64'd4);
    chk({tag, " result"}, 64'(result_u), 64'(r));
    chk({tag, " cout"}, 64'(cout_u), 64'(co));
    chk({tag, " ovf_unsigned"}, 64'(ovf_u), 64'(ovu));
    chk({tag, " ovf_signed"}, 64'(ovf_s), 64'(ovs));
    chk({tag, " result_signed_inst"}, 64'(result_s), 64'(r));
    $display("op %s a=%h b=%h add=%0d cin=%0d -> r=%h cout=%0d ovu=%0d ovs=%0d lat=%0d",
             tag, a, b, add, c, result_u, cout_u, ovf_u, ovf_s, lat);
    last_r = r;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, r;
    logic add, c, co, ovu, ovs;
    int lat, bc, bad, seen;

    vecs[0] = '{"add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b1, CIN_DEFAULT_ADD, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{"sub_borrow", 32'h00000000, 32'h00000001, 1'b0, CIN_DEFAULT_SUB, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{"sub_5_3",    32'h00000005, 32'h00000003, 1'b0, CIN_DEFAULT_SUB, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"add_smax",   32'h7FFFFFFF, 32'h00000001, 1'b1, CIN_DEFAULT_ADD, 32'h80000000, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"sub_smin",   32'h80000000, 32'h00000001, 1'b0, CIN_DEFAULT_SUB, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{"add_chain",  32'h000000FF, 32'h00000001, 1'b1, 1'b0,            32'h00000100, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"add_cin1",   32'h12345678, 32'h00000000, 1'b1, 1'b1,            32'h12345679, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"sub_cin0",   32'h00000010, 32'h00000010, 1'b0, 1'b0,            32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};

    sclr = 1'b1; clken = 1'b1; start = 1'b0; add_sub = 1'b1; cin = 1'b0;
    dataa = '0; datab = '0;
    repeat (3) @(negedge clock);
    chk("reset busy", 64'(busy_u), 64'd0);
    chk("reset done", 64'(done_u), 64'd0);
    chk("reset result", 64'(result_u), 64'd0);
    chk("reset cout", 64'(cout_u), 64'd0);
    chk("reset ovf_u", 64'(ovf_u), 64'd0);
    chk("reset ovf_s", 64'(ovf_s), 64'd0);
    $display("reset: busy=%0d done=%0d result=%h", busy_u, done_u, result_u);
    sclr = 1'b0;

    for (int i = 0; i < 8; i++)
      run_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].add, vecs[i].c,
                vecs[i].r, vecs[i].co, vecs[i].ovu, vecs[i].ovs);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = ~a;
      if ($urandom_range(0, 5) == 0) a = {1'b0, {(W-1){1'b1}}};
      add = 1'($urandom_range(0, 1));
      c   = 1'($urandom_range(0, 1));
      model(a, b, add, c, r, co, ovu, ovs);
      run_check("rand", a, b, add, c, r, co, ovu, ovs);
    end

    // Stall during slice 2, then stretch done by holding clken low while it is high.
    issue(32'h01020304, 32'h10203040, 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    clken = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (!busy_u || done_u || result_u !== last_r) bad++;
    end
    chk("stall frozen_cycles_bad", 64'(bad), 64'd0);
    clken = 1'b1;
    wait_done(lat, bc);
    chk("stall latency", 64'(2 + 3 + lat), 64'd7);
    chk("stall result", 64'(result_u), 64'h11223344);
    $display("op stall r=%h total_lat=%0d", result_u, 2 + 3 + lat);
    last_r = 32'h11223344;
    clken = 1'b0;
    @(negedge clock);
    chk("stretch done_1", 64'(done_u), 64'd1);
    @(negedge clock);
    chk("stretch done_2", 64'(done_u), 64'd1);
    clken = 1'b1;
    @(negedge clock);
    chk("stretch done_end", 64'(done_u), 64'd0);
    chk("stretch result_held", 64'(result_u), 64'h11223344);

    // Abort mid-run with sclr.
    issue(32'hDEADBEEF, 32'h01010101, 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    sclr = 1'b1;
    @(negedge clock);
    chk("abort busy", 64'(busy_u), 64'd0);
    chk("abort done", 64'(done_u), 64'd0);
    chk("abort result", 64'(result_u), 64'd0);
    chk("abort cout", 64'(cout_u), 64'd0);
    sclr = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (done_u || busy_u) seen++;
    end
    chk("abort no_activity", 64'(seen), 64'd0);
    $display("op abort result=%h busy=%0d", result_u, busy_u);
    run_check("after_abort", 32'h00000300, 32'h00000200, 1'b0, 1'b1, 32'h00000100, 1'b1, 1'b0, 1'b0);

    // start held through RUN, then a new op captured in the DONE cycle.
    @(negedge clock);
    dataa = 32'hAAAA5555; datab = 32'h11111111; add_sub = 1'b1; cin = 1'b0; start = 1'b1;
    @(negedge clock);
    wait_done(lat, bc);
    chk("b2b first_latency", 64'(lat), 64'd4);
    chk("b2b first_result", 64'(result_u), 64'hBBBB6666);
    dataa = 32'h00000100; datab = 32'h00000001; add_sub = 1'b0; cin = 1'b1;
    @(negedge clock);
    start = 1'b0;
    lat = 0;
    bad = 0;
    while (!done_u && lat < 20) begin
      if (result_u !== 32'hBBBB6666) bad++;
      @(negedge clock);
      lat++;
    end
    chk("b2b result_held", 64'(bad), 64'd0);
    chk("b2b second_latency", 64'(lat), 64'd4);
    chk("b2b second_result", 64'(result_u), 64'h000000FF);
    chk("b2b second_cout", 64'(cout_u), 64'd1);
    chk("b2b second_ovf", 64'(ovf_u), 64'd0);
    $display("op b2b second r=%h lat=%0d", result_u, lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
